// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
// Shared definitions for the PLL lock sequencer: the FSM state encoding,
// parameter defaults and a helper that sizes the saturating counters.
// No ports.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_READY     = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_e;

    localparam int DEF_RST_CYCLES          = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 500000;
    localparam int DEF_MAX_RETRIES         = 3;

    // $clog2 of the parameter, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk_i   - destination clock
//   rst_n_i - asynchronous active-low reset, clears both flops
//   d_i     - asynchronous input
//   q_o     - synchronized output (two clk_i edges of latency)
module sync_2ff (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Drives the PLL reset, waits for a stable lock, retries on timeout and
// declares the PLL clocks ready. All outputs are registered.
// Ports:
//   refclk       - PLL reference clock, sole clock of this block
//   rst_n        - asynchronous active-low reset
//   pll_locked   - PLL lock flag, asynchronous to refclk
//   sw_reset_req - single-cycle request to restart the sequence
//   pll_rst      - active-high reset to the PLL
//   clocks_ready - PLL outputs declared stable
//   lock_lost    - one-cycle pulse when lock drops while ready
//   fault        - retries exhausted
//   retry_count  - retries consumed in the current sequence
//
// state        | meaning
// -------------+-----------------------------------------------------
// RESET_PLL    | pll_rst held high for RST_CYCLES cycles
// WAIT_LOCK    | pll_rst released, waiting for locked_s, with timeout
// STABILIZE    | counting consecutive locked_s samples
// READY        | clocks_ready high, watching for loss of lock
// FAULT        | retries exhausted, PLL held in reset until sw/rst_n
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES          = DEF_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       pll_rst,
    output logic       clocks_ready,
    output logic       lock_lost,
    output logic       fault,
    output logic [3:0] retry_count
);

    localparam int RW = cnt_width(RST_CYCLES);
    localparam int SW = cnt_width(LOCK_STABLE_CYCLES);
    localparam int TW = cnt_width(LOCK_TIMEOUT_CYCLES);

    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    // The WAIT_LOCK sample that enters STABILIZE is the first of the
    // LOCK_STABLE_CYCLES samples, so STABILIZE only needs the remaining ones.
    localparam logic [SW-1:0] STB_LAST =
        SW'((LOCK_STABLE_CYCLES >= 2) ? (LOCK_STABLE_CYCLES - 2) : 0);
    localparam logic [3:0] MAX_RET = 4'(MAX_RETRIES);

    pll_state_e    state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [SW-1:0] stb_cnt_q, stb_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic          pll_rst_q, pll_rst_d;
    logic          ready_q, ready_d;
    logic          lock_lost_q, lock_lost_d;
    logic          fault_q, fault_d;
    logic          locked_s;

    sync_2ff u_sync (
        .clk_i   (refclk),
        .rst_n_i (rst_n),
        .d_i     (pll_locked),
        .q_o     (locked_s)
    );

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET_PLL;
            rst_cnt_q   <= '0;
            stb_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            stb_cnt_q   <= stb_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        stb_cnt_d   = stb_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;

        if (sw_reset_req) begin
            state_d   = ST_RESET_PLL;
            rst_cnt_d = '0;
            retry_d   = '0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d   = ST_WAIT_LOCK;
                        tmo_cnt_d = '0;
                    end else if (rst_cnt_q != '1) begin
                        rst_cnt_d = rst_cnt_q + RW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        if (LOCK_STABLE_CYCLES == 1) begin
                            state_d = ST_READY;
                            retry_d = '0;
                        end else begin
                            state_d   = ST_STABILIZE;
                            stb_cnt_d = '0;
                        end
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        if (retry_q < MAX_RET) begin
                            retry_d   = retry_q + 4'd1;
                            state_d   = ST_RESET_PLL;
                            rst_cnt_d = '0;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end else if (tmo_cnt_q != '1) begin
                        tmo_cnt_d = tmo_cnt_q + TW'(1);
                    end
                end
                ST_STABILIZE: begin
                    if (!locked_s) begin
                        state_d   = ST_WAIT_LOCK;
                        tmo_cnt_d = '0;
                    end else if (stb_cnt_q == STB_LAST) begin
                        state_d = ST_READY;
                        retry_d = '0;
                    end else if (stb_cnt_q != '1) begin
                        stb_cnt_d = stb_cnt_q + SW'(1);
                    end
                end
                ST_READY: begin
                    if (!locked_s) begin
                        state_d     = ST_RESET_PLL;
                        rst_cnt_d   = '0;
                        lock_lost_d = 1'b1;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d   = ST_RESET_PLL;
                    rst_cnt_d = '0;
                end
            endcase
        end

        // Outputs decode the next state so they change on the transition edge.
        pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
        ready_d   = (state_d == ST_READY);
        fault_d   = (state_d == ST_FAULT);
    end

    assign pll_rst      = pll_rst_q;
    assign clocks_ready = ready_q;
    assign lock_lost    = lock_lost_q;
    assign fault        = fault_q;
    assign retry_count  = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
module tb_pll_lock_sequencer;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       pll_rst;
    logic       clocks_ready;
    logic       lock_lost;
    logic       fault;
    logic [3:0] retry_count;

    pll_lock_sequencer #(
        .RST_CYCLES          (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (100),
        .MAX_RETRIES         (3)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .sw_reset_req (sw_reset_req),
        .pll_rst      (pll_rst),
        .clocks_ready (clocks_ready),
        .lock_lost    (lock_lost),
        .fault        (fault),
        .retry_count  (retry_count)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef struct {
        int         cyc;   // -1: any cycle
        logic [7:0] v;     // {pll_rst, clocks_ready, lock_lost, fault, retry_count}
    } ev_t;

    ev_t        exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    int         ev_idx = 0;
    logic [7:0] prev_outs;
    logic [7:0] cur_outs;
    bit         seen_first = 1'b0;
    ev_t        mon_ev;

    always @(posedge refclk) cyc = cyc + 1;

    function automatic logic [7:0] o(input bit pr, input bit cr, input bit ll,
                                     input bit f, input int rc);
        logic [3:0] r;
        r = 4'(rc);
        return {pr, cr, ll, f, r};
    endfunction

    task automatic push_exp(input int c, input logic [7:0] v);
        ev_t e;
        e.cyc = c;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // Monitor: every change of the output vector is one DUT event, checked
    // against the oldest pending expectation (value and cycle).
    always @(negedge refclk) begin
        cur_outs = {pll_rst, clocks_ready, lock_lost, fault, retry_count};
        if (!seen_first || cur_outs !== prev_outs) begin
            seen_first = 1'b1;
            prev_outs  = cur_outs;
            tests      = tests + 1;
            ev_idx     = ev_idx + 1;
            if (exp_q.size() == 0) begin
                fails = fails + 1;
                $display("FAIL ev%0d_unexpected got=%h at cyc %0d, expected no change",
                         ev_idx, cur_outs, cyc);
            end else begin
                mon_ev = exp_q.pop_front();
                if (cur_outs !== mon_ev.v || (mon_ev.cyc >= 0 && mon_ev.cyc != cyc)) begin
                    fails = fails + 1;
                    $display("FAIL ev%0d got=%h at cyc %0d, expected %h at cyc %0d",
                             ev_idx, cur_outs, cyc, mon_ev.v, mon_ev.cyc);
                end
            end
        end
    end

    initial begin
        int t0;
        ev_t e;
        rst_n        = 1'b0;
        pll_locked   = 1'b0;
        sw_reset_req = 1'b0;
        push_exp(-1, o(1, 0, 0, 0, 0));
        tick(3);

        // Normal start-up: pll_rst 4 cycles, ready 10 cycles after lock edge.
        rst_n = 1'b1;
        t0 = cyc;
        push_exp(t0 + 4, o(0, 0, 0, 0, 0));
        tick(20);
        pll_locked = 1'b1;
        t0 = cyc;
        push_exp(t0 + 10, o(0, 1, 0, 0, 0));
        tick(15);

        // Lock loss from READY.
        pll_locked = 1'b0;
        t0 = cyc;
        push_exp(t0 + 3, o(1, 0, 1, 0, 0));
        push_exp(t0 + 4, o(1, 0, 0, 0, 0));
        push_exp(t0 + 7, o(0, 0, 0, 0, 0));
        tick(10);

        // Glitch during STABILIZE: ready 10 cycles after the second rise.
        pll_locked = 1'b1;
        t0 = cyc;
        push_exp(t0 + 16, o(0, 1, 0, 0, 0));
        tick(5);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(15);

        // Timeouts: three retries then FAULT.
        pll_locked = 1'b0;
        t0 = cyc;
        push_exp(t0 + 3, o(1, 0, 1, 0, 0));
        push_exp(t0 + 4, o(1, 0, 0, 0, 0));
        push_exp(t0 + 7, o(0, 0, 0, 0, 0));
        for (int k = 1; k <= 3; k++) begin
            push_exp(t0 + 107 + 104 * (k - 1), o(1, 0, 0, 0, k));
            push_exp(t0 + 111 + 104 * (k - 1), o(0, 0, 0, 0, k));
        end
        push_exp(t0 + 107 + 104 * 3, o(1, 0, 0, 1, 3));
        tick(430);

        // Software recovery from FAULT, then a normal lock.
        sw_reset_req = 1'b1;
        t0 = cyc;
        push_exp(t0 + 1, o(1, 0, 0, 0, 0));
        push_exp(t0 + 5, o(0, 0, 0, 0, 0));
        tick(1);
        sw_reset_req = 1'b0;
        tick(8);
        pll_locked = 1'b1;
        t0 = cyc;
        push_exp(t0 + 10, o(0, 1, 0, 0, 0));
        tick(14);

        // Drop lock, relock, then assert rst_n asynchronously mid-STABILIZE.
        pll_locked = 1'b0;
        t0 = cyc;
        push_exp(t0 + 3, o(1, 0, 1, 0, 0));
        push_exp(t0 + 4, o(1, 0, 0, 0, 0));
        push_exp(t0 + 7, o(0, 0, 0, 0, 0));
        tick(10);
        pll_locked = 1'b1;
        tick(5);
        #2;
        push_exp(cyc, o(1, 0, 0, 0, 0));
        rst_n = 1'b0;
        #1;
        tests = tests + 1;
        if ({pll_rst, clocks_ready, lock_lost, fault, retry_count} !== 8'h80) begin
            fails = fails + 1;
            $display("FAIL async_reset got=%h, expected 80",
                     {pll_rst, clocks_ready, lock_lost, fault, retry_count});
        end
        tick(3);

        // Release with lock already present: synchronizer restarts from 0.
        rst_n = 1'b1;
        t0 = cyc;
        push_exp(t0 + 4, o(0, 0, 0, 0, 0));
        push_exp(t0 + 12, o(0, 1, 0, 0, 0));
        tick(16);

        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL missing_event got=none, expected %h at cyc %0d", e.v, e.cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16, cycles pll_rst is held high per reset attempt (min 1).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, consecutive synchronized-locked cycles required before ready (min 1).
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 500000, cycles allowed in WAIT_LOCK before a retry (min 2).
REQ-004 SHALL have parameter MAX_RETRIES, default 3, retries before FAULT (0..15).
REQ-005 SHALL have port refclk, input, 1, sole clock (50 MHz PLL reference).
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port pll_locked, input, 1, PLL locked flag, asynchronous to refclk.
REQ-008 SHALL have port sw_reset_req, input, 1, single-cycle request to restart the sequence.
REQ-009 SHALL have port pll_rst, output, 1, active-high reset to the PLL.
REQ-010 SHALL have port clocks_ready, output, 1, high only while the PLL outputs are declared stable.
REQ-011 SHALL have port lock_lost, output, 1, one-cycle pulse on loss of lock from READY.
REQ-012 SHALL have port fault, output, 1, high in FAULT.
REQ-013 SHALL have port retry_count, output, 4, retries consumed in the current sequence.

Function
REQ-014 SHALL pass pll_locked through a 2-flop synchronizer; every "locked" condition below refers to the synchronizer output (locked_s).
REQ-015 SHALL implement states RESET_PLL, WAIT_LOCK, STABILIZE, READY, FAULT; all outputs registered.
REQ-016 RESET_PLL: pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with the timeout counter cleared.
REQ-017 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABILIZE with the stable counter cleared; otherwise timeout counter increments.
REQ-018 Timeout (counter reaches LOCK_TIMEOUT_CYCLES-1 without lock): retry_count<MAX_RETRIES -> retry_count+1, RESET_PLL; else -> FAULT.
REQ-019 STABILIZE: locked_s=0 on any cycle -> WAIT_LOCK with the timeout counter cleared; LOCK_STABLE_CYCLES consecutive locked_s=1 samples -> READY.
REQ-020 clocks_ready SHALL rise on the clock edge that enters READY: latency from the first locked_s=1 cycle is exactly LOCK_STABLE_CYCLES cycles.
REQ-021 Entering READY SHALL clear retry_count to 0.
REQ-022 READY: locked_s=0 -> RESET_PLL, clocks_ready=0 and lock_lost=1 on the same edge; lock_lost=0 on the next edge.
REQ-023 FAULT: pll_rst=1, fault=1, clocks_ready=0; exit only via sw_reset_req or rst_n.
REQ-024 sw_reset_req=1 SHALL, in any state, force RESET_PLL with retry_count=0, fault=0, clocks_ready=0, overriding all other transitions that cycle; lock_lost SHALL NOT pulse.
REQ-025 Counters SHALL be sized by $clog2 of their parameter and SHALL saturate, never wrap.

Reset
REQ-026 rst_n=0 SHALL immediately force state=RESET_PLL, pll_rst=1, clocks_ready=0, lock_lost=0, fault=0, retry_count=0, counters and synchronizer to 0.
REQ-027 After rst_n deasserts, pll_rst SHALL stay high for RST_CYCLES further cycles.

Structure
REQ-028 State enum and parameter defaults SHALL live in shared package pll_seq_pkg.
REQ-029 The synchronizer SHALL be the sub-module sync_2ff (1-bit, rst_n-cleared).

Verification (RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=100, MAX_RETRIES=3)
REQ-030 Normal: release rst_n, pll_locked raised 20 cycles later -> pll_rst high 4 cycles; clocks_ready rises exactly 2+8 cycles after the pll_locked edge; retry_count=0.
REQ-031 Glitch: pll_locked high 5 cycles, low 1, high -> return to WAIT_LOCK; clocks_ready rises 10 cycles after the second rising edge.
REQ-032 Timeout: pll_locked held 0 -> 3 RESET_PLL re-entries, retry_count 1,2,3, then fault=1 with pll_rst held 1 after the 4th timeout.
REQ-033 Lock loss: drop pll_locked in READY -> clocks_ready=0 and one-cycle lock_lost 3 edges later, then pll_rst high 4 cycles.
REQ-034 Recovery: sw_reset_req pulse in FAULT -> fault=0, retry_count=0, pll_rst high 4 cycles, normal sequence resumes.
REQ-035 Reset mid-STABILIZE: assert rst_n=0 asynchronously -> all outputs reach REQ-026 values before the next refclk edge.
